// File: rtl/delta_pkg.sv
// Shared constants and helpers for the streaming delta modulator: mode encodings,
// derived widths and saturating arithmetic that never wraps.
package delta_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_ADAPT = 1'b1;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bit counter only ever holds 0..PACK_W-1 because it clears on reaching PACK_W.
    function automatic int cnt_width(input int pack_w);
        return (pack_w <= 2) ? 1 : $clog2(pack_w);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/delta_step_adapt.sv
// Combinational decision/step/accumulator update for one channel sample.
// Fixed mode uses step_init directly; adaptive mode doubles on a run of three, else halves.
module delta_step_adapt
    import delta_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 64
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] step,
    input  logic              last,
    input  logic [1:0]        run,
    input  logic              mode,
    input  logic [DATA_W-1:0] step_init,
    output logic              b,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] step_next,
    output logic [1:0]        run_next
);

    localparam int                SW         = DATA_W + 1;
    localparam logic [SW-1:0]     STEP_MAX_W = SW'(STEP_MAX);
    localparam logic [DATA_W-1:0] STEP_MIN_V = DATA_W'(STEP_MIN);
    localparam logic [DATA_W-1:0] ACC_MAX    = '1;

    logic [SW-1:0]     step_dbl;
    logic [DATA_W-1:0] step_half;

    always_comb begin
        b = (sample >= acc);

        if (b == last) begin
            run_next = (run == 2'd3) ? 2'd3 : run + 2'd1;
        end else begin
            run_next = 2'd1;
        end

        // Doubling carries one extra bit so a large step clamps instead of wrapping.
        step_dbl  = {step, 1'b0};
        step_half = step >> 1;

        if (mode == MODE_FIXED) begin
            step_next = step_init;
        end else if (run_next == 2'd3) begin
            step_next = (step_dbl > STEP_MAX_W) ? STEP_MAX_W[DATA_W-1:0] : step_dbl[DATA_W-1:0];
        end else begin
            step_next = (step_half < STEP_MIN_V) ? STEP_MIN_V : step_half;
        end

        if (b) begin
            acc_next = DATA_W'(sat_add(32'(acc), 32'(step_next), 32'(ACC_MAX)));
        end else begin
            acc_next = DATA_W'(sat_sub(32'(acc), 32'(step_next)));
        end
    end

endmodule

// File: rtl/delta_mod_stream.sv
// Multi-channel 1-bit delta modulator: per-channel tracking state, bit packing
// and a registered valid/ready output word stream.
module delta_mod_stream
    import delta_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_CH   = 8,
    parameter int PACK_W   = 8,
    parameter int STEP_MIN = 1,
    parameter int STEP_MAX = 64,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              CLK100MHZ,
    input  logic              RESET,
    input  logic              clear,
    input  logic              mode,
    input  logic [DATA_W-1:0] step_init,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [CH_W-1:0]   s_ch,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PACK_W-1:0] m_data,
    output logic [CH_W-1:0]   m_ch,
    output logic              err_ch
);

    localparam int                CNT_W    = cnt_width(PACK_W);
    localparam logic [DATA_W-1:0] STEP_RST = DATA_W'(STEP_MIN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PACK_W - 1);

    logic [DATA_W-1:0] acc_q   [NUM_CH];
    logic [DATA_W-1:0] acc_d   [NUM_CH];
    logic [DATA_W-1:0] step_q  [NUM_CH];
    logic [DATA_W-1:0] step_d  [NUM_CH];
    logic              last_q  [NUM_CH];
    logic              last_d  [NUM_CH];
    logic [1:0]        run_q   [NUM_CH];
    logic [1:0]        run_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [PACK_W-1:0] shreg_q [NUM_CH];
    logic [PACK_W-1:0] shreg_d [NUM_CH];

    logic              m_valid_q, m_valid_d;
    logic [PACK_W-1:0] m_data_q, m_data_d;
    logic [CH_W-1:0]   m_ch_q, m_ch_d;
    logic              err_q, err_d;

    logic              accept, ch_ok, hit, complete;
    logic [CH_W-1:0]   idx;
    logic              b;
    logic [DATA_W-1:0] acc_nx, step_nx;
    logic [1:0]        run_nx;

    assign s_ready  = !m_valid_q || m_ready;
    assign accept   = s_valid && s_ready;
    assign ch_ok    = (32'(s_ch) < NUM_CH);
    // Out-of-range tags are steered to channel 0 only to keep array reads in bounds.
    assign idx      = ch_ok ? s_ch : '0;
    assign hit      = accept && ch_ok && !clear;
    assign complete = hit && (cnt_q[idx] == CNT_LAST);

    delta_step_adapt #(
        .DATA_W  (DATA_W),
        .STEP_MIN(STEP_MIN),
        .STEP_MAX(STEP_MAX)
    ) u_adapt (
        .sample   (s_data),
        .acc      (acc_q[idx]),
        .step     (step_q[idx]),
        .last     (last_q[idx]),
        .run      (run_q[idx]),
        .mode     (mode),
        .step_init(step_init),
        .b        (b),
        .acc_next (acc_nx),
        .step_next(step_nx),
        .run_next (run_nx)
    );

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_d[c]   = acc_q[c];
            step_d[c]  = step_q[c];
            last_d[c]  = last_q[c];
            run_d[c]   = run_q[c];
            cnt_d[c]   = cnt_q[c];
            shreg_d[c] = shreg_q[c];
            if (clear) begin
                acc_d[c]   = '0;
                step_d[c]  = STEP_RST;
                last_d[c]  = 1'b0;
                run_d[c]   = 2'd0;
                cnt_d[c]   = '0;
                shreg_d[c] = '0;
            end else if (hit && (idx == CH_W'(c))) begin
                acc_d[c]   = acc_nx;
                if (mode == MODE_ADAPT) begin
                    step_d[c] = step_nx;
                end
                last_d[c]  = b;
                run_d[c]   = run_nx;
                cnt_d[c]   = (cnt_q[c] == CNT_LAST) ? '0 : cnt_q[c] + CNT_W'(1);
                shreg_d[c] = {shreg_q[c][PACK_W-2:0], b};
            end
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ch_d    = m_ch_q;
        err_d     = 1'b0;
        if (clear) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_ch_d    = '0;
        end else begin
            err_d = accept && !ch_ok;
            // A completion implies s_ready, so any held word is being consumed now.
            if (complete) begin
                m_valid_d = 1'b1;
                m_data_d  = {shreg_q[idx][PACK_W-2:0], b};
                m_ch_d    = s_ch;
            end else if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c]   <= '0;
                step_q[c]  <= STEP_RST;
                last_q[c]  <= 1'b0;
                run_q[c]   <= 2'd0;
                cnt_q[c]   <= '0;
                shreg_q[c] <= '0;
            end
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            step_q    <= step_d;
            last_q    <= last_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_ch_q    <= m_ch_d;
            err_q     <= err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ch    = m_ch_q;
    assign err_ch  = err_q;

endmodule

// File: tb/tb_delta_mod_stream.sv
// Directed bench: a vector table of accepted samples with expected accumulator, step
// and output word, followed by hand sequences for stall, reset, clear and bad tags.
module tb_delta_mod_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] step_init = 8'd16;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'd0;
    logic       s_ch = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [3:0] m_data;
    logic       m_ch;
    logic       err_ch;

    logic       s_valid3 = 1'b0;
    logic       s_ready3;
    logic [7:0] s_data3 = 8'd0;
    logic [1:0] s_ch3 = 2'd0;
    logic       m_valid3;
    logic [3:0] m_data3;
    logic [1:0] m_ch3;
    logic       err3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    delta_mod_stream #(.DATA_W(8), .NUM_CH(2), .PACK_W(4), .STEP_MIN(1), .STEP_MAX(64)) dut (
        .CLK100MHZ(clk), .RESET(rst), .clear(clear), .mode(mode), .step_init(step_init),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .err_ch(err_ch)
    );

    // Three channels give a 2-bit tag, so an out-of-range tag (3) is expressible.
    delta_mod_stream #(.DATA_W(8), .NUM_CH(3), .PACK_W(4), .STEP_MIN(1), .STEP_MAX(64)) dut3 (
        .CLK100MHZ(clk), .RESET(rst), .clear(clear), .mode(mode), .step_init(step_init),
        .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .s_ch(s_ch3),
        .m_valid(m_valid3), .m_ready(1'b1), .m_data(m_data3), .m_ch(m_ch3), .err_ch(err3)
    );

    typedef struct {
        bit       clr;
        bit       md;
        int       si;
        int       ch;
        int       data;
        int       acc;
        int       step;
        bit       v;
        int       w;
        int       wch;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Called at a negedge; accepts one ch sample and returns at the following negedge.
    task automatic send(input int ch, input int data);
        s_valid = 1'b1;
        s_ch    = ch[0];
        s_data  = data[7:0];
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // clr, mode, step_init, ch, data, acc, step, m_valid, word, word ch
        vt.push_back('{0, 0,  16, 0, 100,  16,  1, 0, 0,  0});
        vt.push_back('{0, 0,  16, 0, 100,  32,  1, 0, 0,  0});
        vt.push_back('{0, 0,  16, 0, 100,  48,  1, 0, 0,  0});
        vt.push_back('{0, 0,  16, 0, 100,  64,  1, 1, 15, 0});
        vt.push_back('{0, 1,  16, 1, 255,   1,  1, 0, 0,  0});
        vt.push_back('{0, 1,  16, 1, 255,   2,  1, 0, 0,  0});
        vt.push_back('{0, 1,  16, 1, 255,   4,  2, 0, 0,  0});
        vt.push_back('{0, 1,  16, 1, 255,   8,  4, 1, 15, 1});
        vt.push_back('{0, 1,  16, 1,   0,   6,  2, 0, 0,  0});
        vt.push_back('{1, 0, 200, 0, 255, 200,  1, 0, 0,  0});
        vt.push_back('{0, 0, 200, 0, 255, 255,  1, 0, 0,  0});
        vt.push_back('{0, 0, 200, 0,   0,  55,  1, 0, 0,  0});
        vt.push_back('{0, 0, 200, 0,   0,   0,  1, 1, 12, 0});
        vt.push_back('{1, 0,   8, 0, 255,   8,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 1,   0,   8,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 0, 255,  16,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 1,   0,   0,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 0, 255,  24,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 1,   0,   8,  1, 0, 0,  0});
        vt.push_back('{0, 0,   8, 0, 255,  32,  1, 1, 15, 0});
        vt.push_back('{0, 0,   8, 1,   0,   0,  1, 1, 10, 1});
        vt.push_back('{1, 1,   8, 1, 255,   1,  1, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255,   2,  1, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255,   4,  2, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255,   8,  4, 1, 15, 1});
        vt.push_back('{0, 1,   8, 1, 255,  16,  8, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255,  32, 16, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255,  64, 32, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1, 255, 128, 64, 1, 15, 1});
        vt.push_back('{0, 1,   8, 1, 255, 192, 64, 0, 0,  0});
        vt.push_back('{0, 1,   8, 1,   0, 160, 32, 0, 0,  0});

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid_async", int'(m_valid), 0);
        rst = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_ch", int'(m_ch), 0);
        chk("rst_err_ch", int'(err_ch), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_step0", int'(dut.step_q[0]), 1);
        @(negedge clk);

        foreach (vt[i]) begin
            if (vt[i].clr) begin
                clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
                chk("clear_m_valid", int'(m_valid), 0);
                chk("clear_acc", int'(dut.acc_q[vt[i].ch]), 0);
                @(negedge clk);
            end
            mode      = vt[i].md;
            step_init = vt[i].si[7:0];
            chk($sformatf("v%0d_s_ready", i), int'(s_ready), 1);
            send(vt[i].ch, vt[i].data);
            $display("vec %0d: ch=%0d data=%0d acc=%0d step=%0d m_valid=%0d m_data=%b m_ch=%0d",
                     i, vt[i].ch, vt[i].data, dut.acc_q[vt[i].ch], dut.step_q[vt[i].ch],
                     m_valid, m_data, m_ch);
            chk($sformatf("v%0d_acc", i), int'(dut.acc_q[vt[i].ch]), vt[i].acc);
            chk($sformatf("v%0d_step", i), int'(dut.step_q[vt[i].ch]), vt[i].step);
            chk($sformatf("v%0d_m_valid", i), int'(m_valid), int'(vt[i].v));
            if (vt[i].v) begin
                chk($sformatf("v%0d_m_data", i), int'(m_data), vt[i].w);
                chk($sformatf("v%0d_m_ch", i), int'(m_ch), vt[i].wch);
            end
        end

        // Back-pressure: the completed word must hold and no sample may be taken.
        mode = 1'b0;
        step_init = 8'd8;
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(0, 255);
        chk("stall_word_valid", int'(m_valid), 1);
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 8'd0;
        for (int k = 0; k < 10; k++) begin
            chk("stall_s_ready", int'(s_ready), 0);
            @(posedge clk);
            #1;
            chk("stall_m_valid", int'(m_valid), 1);
            chk("stall_m_data", int'(m_data), 15);
            chk("stall_m_ch", int'(m_ch), 0);
            chk("stall_acc", int'(dut.acc_q[0]), 32);
            @(negedge clk);
        end
        m_ready = 1'b1;
        #1;
        chk("release_s_ready", int'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        $display("stall release: acc0=%0d m_valid=%0d", dut.acc_q[0], m_valid);
        chk("release_acc", int'(dut.acc_q[0]), 24);
        chk("release_m_valid", int'(m_valid), 0);
        @(negedge clk);

        // Asynchronous reset while a word is held and ch1 has two partial bits.
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 255);
        chk("pre_reset_m_valid", int'(m_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_m_valid", int'(m_valid), 0);
        chk("async_reset_acc1", int'(dut.acc_q[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(1, 255);
            chk("post_reset_partial", int'(m_valid), 0);
        end
        send(1, 255);
        $display("post reset word: m_valid=%0d m_data=%b m_ch=%0d", m_valid, m_data, m_ch);
        chk("post_reset_m_valid", int'(m_valid), 1);
        chk("post_reset_m_data", int'(m_data), 15);
        chk("post_reset_m_ch", int'(m_ch), 1);
        chk("post_reset_acc1", int'(dut.acc_q[1]), 32);

        // Clear coincident with an accept drops that sample.
        clear   = 1'b1;
        s_valid = 1'b1;
        s_ch    = 1'b0;
        s_data  = 8'd255;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        chk("clear_drop_acc0", int'(dut.acc_q[0]), 0);
        chk("clear_drop_m_valid", int'(m_valid), 0);
        @(negedge clk);
        send(0, 255);
        chk("after_clear_acc0", int'(dut.acc_q[0]), 8);
        send(0, 255);
        send(0, 255);
        chk("after_clear_3bits", int'(m_valid), 0);
        send(0, 255);
        chk("after_clear_word", int'(m_valid), 1);
        chk("after_clear_data", int'(m_data), 15);

        // Out-of-range tag on the three-channel instance.
        s_valid3 = 1'b1;
        s_ch3    = 2'd3;
        s_data3  = 8'd255;
        chk("bad_tag_s_ready", int'(s_ready3), 1);
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        $display("bad tag: err_ch=%0d", err3);
        chk("bad_tag_err", int'(err3), 1);
        for (int c = 0; c < 3; c++) chk($sformatf("bad_tag_acc%0d", c), int'(dut3.acc_q[c]), 0);
        chk("bad_tag_m_valid", int'(m_valid3), 0);
        @(posedge clk);
        #1;
        chk("bad_tag_err_pulse", int'(err3), 0);
        @(negedge clk);
        s_valid3 = 1'b1;
        s_ch3    = 2'd2;
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        chk("good_tag_acc2", int'(dut3.acc_q[2]), 8);
        chk("good_tag_err", int'(err3), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
